// File: rtl/baud_defs.sv
// Shared baud-rate constants for the UART clocking blocks (baud generator,
// tx and rx). Defaults here are the ones the rest of the UART assumes.
package baud_defs;

    // Integer-divisor width, fractional width (1/2^FW units) and oversample
    // ratio used by default across the UART.
    localparam int BAUD_IW       = 16;
    localparam int BAUD_FW       = 4;
    localparam int BAUD_OS       = 16;

    // Divisor loaded at reset: 163 cycles per oversample tick.
    localparam int BAUD_DEF_INT  = 163;
    localparam int BAUD_DEF_FRAC = 0;

    // Smallest integer divisor the period counter can realise.
    localparam int BAUD_MIN_INT  = 2;

    // Classification of a divisor-load strobe.
    typedef enum logic [1:0] {
        LD_NONE   = 2'd0,
        LD_ACCEPT = 2'd1,
        LD_REJECT = 2'd2
    } load_kind_e;

endpackage : baud_defs

// File: rtl/baud_frac_div.sv
// Fractional period divider: produces one tick_os pulse per period, where
// the period alternates between a_int and a_int+1 cycles so that the mean
// period is a_int + a_frac/2^FW cycles with no long-run drift.
module baud_frac_div #(
    parameter int IW = 16,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          sync_clr,
    input  logic [IW-1:0] a_int,
    input  logic [FW-1:0] a_frac,
    output logic          tick_os
);

    logic [IW-1:0] cnt;         // position inside the current period
    logic [FW-1:0] acc;         // fractional phase accumulator
    logic          cy;          // carry: this period is one cycle longer

    logic [IW:0]   period_len;  // a_int + cy, one bit wider to hold the carry
    logic [IW:0]   last_cnt;    // period_len - 1
    logic          period_end;
    logic [FW:0]   acc_sum;

    assign period_len = {1'b0, a_int} + {{IW{1'b0}}, cy};
    assign last_cnt   = period_len - (IW+1)'(1);

    // The compare is >= rather than == so that a shorter divisor applied
    // while counting is frozen ends the stretched period on the next enabled
    // cycle instead of letting cnt run all the way round its range. Whenever
    // the divisor only changes at a period boundary the two are identical.
    assign period_end = ({1'b0, cnt} >= last_cnt);

    assign tick_os    = ~reset & en & ~sync_clr & period_end;

    assign acc_sum    = {1'b0, acc} + {1'b0, a_frac};

    // Period counter and phase accumulator; clear has priority over counting.
    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
            cy  <= 1'b0;
        end else if (sync_clr) begin
            cnt <= '0;
            acc <= '0;
            cy  <= 1'b0;
        end else if (en) begin
            if (period_end) begin
                cnt       <= '0;
                {cy, acc} <= acc_sum;
            end else begin
                cnt <= cnt + IW'(1);
            end
        end
    end

endmodule : baud_frac_div

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator. Produces the oversample tick, the mid-bit
// tick and the bit-boundary tick for the UART, with a double-buffered divisor
// so that a new rate only takes effect on a period boundary.
module baud_gen_frac
    import baud_defs::*;
#(
    parameter int IW       = BAUD_IW,
    parameter int FW       = BAUD_FW,
    parameter int OS       = BAUD_OS,       // power of two, at least 4
    parameter int DEF_INT  = BAUD_DEF_INT,
    parameter int DEF_FRAC = BAUD_DEF_FRAC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          sync_clr,
    input  logic          div_load,
    input  logic [IW-1:0] div_int,
    input  logic [FW-1:0] div_frac,
    output logic          tick_os,
    output logic          tick_half,
    output logic          tick_bit,
    output logic          cfg_pending,
    output logic          cfg_err
);

    localparam int OSW = $clog2(OS);

    // Active divisor seen by the period divider.
    logic [IW-1:0]  a_int;
    logic [FW-1:0]  a_frac;

    // Accepted divisor waiting for the next period boundary.
    logic [IW-1:0]  p_int;
    logic [FW-1:0]  p_frac;
    logic           pending;

    logic [OSW-1:0] osc;        // oversample tick index within the bit
    logic           tick_os_i;
    load_kind_e     load_kind;
    logic           apply_now;  // this edge may swap the active divisor

    baud_frac_div #(
        .IW (IW),
        .FW (FW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr),
        .a_int    (a_int),
        .a_frac   (a_frac),
        .tick_os  (tick_os_i)
    );

    // Classify the load strobe: divisors below the minimum are refused.
    // NOTE: the default assignment first keeps this purely combinational;
    // without it a path that skips the assignment would infer a latch.
    always_comb begin
        load_kind = LD_NONE;
        if (div_load) begin
            load_kind = (div_int >= IW'(BAUD_MIN_INT)) ? LD_ACCEPT : LD_REJECT;
        end
    end

    // A swap is safe at the end of a period, or whenever counting is frozen
    // or being cleared, since no period is then in progress to distort.
    assign apply_now = tick_os_i | ~en | sync_clr;

    // Divisor double buffer: a load in a tick cycle goes straight to the
    // active register so it governs the very next period; otherwise it waits
    // in the pending register, and a later load simply overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_int   <= IW'(DEF_INT);
            a_frac  <= FW'(DEF_FRAC);
            p_int   <= '0;
            p_frac  <= '0;
            pending <= 1'b0;
        end else if (load_kind == LD_ACCEPT && tick_os_i) begin
            a_int   <= div_int;
            a_frac  <= div_frac;
            pending <= 1'b0;
        end else if (load_kind == LD_ACCEPT) begin
            p_int   <= div_int;
            p_frac  <= div_frac;
            pending <= 1'b1;
        end else if (pending && apply_now) begin
            a_int   <= p_int;
            a_frac  <= p_frac;
            pending <= 1'b0;
        end
    end

    // Oversample counter: advances once per tick_os and wraps naturally at OS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            osc <= '0;
        end else if (sync_clr) begin
            osc <= '0;
        end else if (tick_os_i) begin
            osc <= osc + OSW'(1);
        end
    end

    assign tick_os     = tick_os_i;
    assign tick_half   = tick_os_i & (osc == OSW'(OS/2 - 1));
    assign tick_bit    = tick_os_i & (osc == OSW'(OS - 1));
    assign cfg_pending = pending;
    assign cfg_err     = ~reset & (load_kind == LD_REJECT);

endmodule : baud_gen_frac
